// File: rtl/uart_pkg.sv
// Shared UART definitions: parity mode encodings and the baud divider helper.
// Used by the transmitter and intended for the matching receiver.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    // Clock cycles per bit, rounded to the nearest integer.
    function automatic int baud_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Valid/ready word stream into the buffered UART transmitter.
interface uart_tx_fifo_if #(
    parameter int DATA_BITS = 8
) ();

    logic [DATA_BITS-1:0] in_data;
    logic                 in_valid;
    logic                 in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );

endinterface

// File: rtl/uart_fifo.sv
// Synchronous FIFO with power-of-two depth. Pointers carry one extra wrap
// bit so full and empty are distinguished without a separate flag.
// Read data is show-ahead: data_o is the head word whenever empty_o is low.
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             data_i,
    input  logic                         pop_i,
    output logic [WIDTH-1:0]             data_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             push_ok;
    logic             pop_ok;

    assign count_o = wr_ptr_q - rd_ptr_q;
    assign full_o  = (count_o == ($clog2(DEPTH+1))'(DEPTH));
    assign empty_o = (count_o == '0);
    assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    // Pointer advance on accepted push / pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    // Pointer registers; reset empties the queue, contents become don't-care.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage write; no reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: words queue in a FIFO and are sent LSB-first
// with start bit, optional parity and one or two stop bits. Back-to-back
// frames follow without an idle gap while the FIFO holds data.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 48000000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    uart_tx_fifo_if.slave                     s_if,
    output logic                              serial_txd_o,
    output logic                              busy_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count_o
);

    localparam int DIV   = baud_div(CLK_HZ, BAUD);
    localparam int DIV_W = (DIV > 2) ? $clog2(DIV) : 1;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    if (DIV < 2) begin : g_div_check
        $error("uart_tx_fifo: bit period below 2 clock cycles");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bits_check
        $error("uart_tx_fifo: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_parity_check
        $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_stop_check
        $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_check
        $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
    end

    logic [2:0]           state_q,   state_d;
    logic [DIV_W-1:0]     div_cnt_q, div_cnt_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q,   shift_d;
    logic                 parity_q,  parity_d;
    logic                 txd_q,     txd_d;
    logic                 busy_q,    busy_d;

    logic                 fifo_pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [DATA_BITS-1:0] fifo_rdata;
    logic                 load_parity;
    logic                 div_last;

    uart_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (s_if.in_valid),
        .data_i  (s_if.in_data),
        .pop_i   (fifo_pop),
        .data_o  (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count_o)
    );

    // Ready comes from the registered count, so a pop this cycle cannot raise it.
    assign s_if.in_ready = !fifo_full;
    assign serial_txd_o  = txd_q;
    assign busy_o        = busy_q;

    // Even parity is the XOR of the data bits; odd is its inverse.
    assign load_parity = (^fifo_rdata) ^ (PARITY == PARITY_ODD);
    assign div_last    = (div_cnt_q == DIV_W'(DIV - 1));

    // Frame sequencing: bit timing, shifting and the next-word pop.
    always_comb begin
        state_d   = state_q;
        div_cnt_d = div_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        txd_d     = txd_q;
        busy_d    = busy_q;
        fifo_pop  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                txd_d     = 1'b1;
                busy_d    = 1'b0;
                div_cnt_d = '0;
                bit_cnt_d = '0;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_rdata;
                    parity_d = load_parity;
                    txd_d    = 1'b0;
                    busy_d   = 1'b1;
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                if (div_last) begin
                    div_cnt_d = '0;
                    bit_cnt_d = '0;
                    txd_d     = shift_q[0];
                    shift_d   = shift_q >> 1;
                    state_d   = ST_DATA;
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
            end
            ST_DATA: begin
                if (div_last) begin
                    div_cnt_d = '0;
                    if (bit_cnt_q == 4'(DATA_BITS - 1)) begin
                        bit_cnt_d = '0;
                        if (PARITY != PARITY_NONE) begin
                            txd_d   = parity_q;
                            state_d = ST_PARITY;
                        end else begin
                            txd_d   = 1'b1;
                            state_d = ST_STOP;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        txd_d     = shift_q[0];
                        shift_d   = shift_q >> 1;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
            end
            ST_PARITY: begin
                if (div_last) begin
                    div_cnt_d = '0;
                    bit_cnt_d = '0;
                    txd_d     = 1'b1;
                    state_d   = ST_STOP;
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
            end
            ST_STOP: begin
                if (div_last) begin
                    div_cnt_d = '0;
                    if (bit_cnt_q == 4'(STOP_BITS - 1)) begin
                        bit_cnt_d = '0;
                        if (!fifo_empty) begin
                            fifo_pop = 1'b1;
                            shift_d  = fifo_rdata;
                            parity_d = load_parity;
                            txd_d    = 1'b0;
                            state_d  = ST_START;
                        end else begin
                            txd_d   = 1'b1;
                            busy_d  = 1'b0;
                            state_d = ST_IDLE;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
            end
            default: begin
                txd_d   = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset drops the line high immediately and abandons any frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            txd_q     <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            txd_q     <= txd_d;
            busy_q    <= busy_d;
        end
    end

endmodule
